// File: rtl/fpga_ram_arb_pkg.sv
// rtl/fpga_ram_arb_pkg.sv - shared types and constants for the RAM bank arbiter
package fpga_ram_arb_pkg;

   localparam int NUM_MASTERS = 2;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/fpga_ram_bank_arbiter.sv
// rtl/fpga_ram_bank_arbiter.sv - two-master round-robin arbiter for a single-port RAM bank with zero-fill
module fpga_ram_bank_arbiter
   import fpga_ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter bit INIT_ZERO  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  m0_req_i,
   output logic                  m0_gnt_o,
   input  logic                  m0_wen_i,
   input  logic [3:0]            m0_be_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [31:0]           m0_wdata_i,
   output logic                  m0_rvalid_o,
   output logic [31:0]           m0_rdata_o,

   input  logic                  m1_req_i,
   output logic                  m1_gnt_o,
   input  logic                  m1_wen_i,
   input  logic [3:0]            m1_be_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [31:0]           m1_wdata_i,
   output logic                  m1_rvalid_o,
   output logic [31:0]           m1_rdata_o,

   output logic                  ram_csn_o,
   output logic                  ram_wen_o,
   output logic [3:0]            ram_be_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   input  logic [31:0]           ram_rdata_i,

   output logic                  init_done_o
);

   localparam state_e RESET_STATE = INIT_ZERO ? INIT : RUN;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
   logic                    rr_q, rr_d;
   logic [NUM_MASTERS-1:0]  rvalid_q, rvalid_d;
   logic [NUM_MASTERS-1:0]  gnt;

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      rr_d        = rr_q;
      gnt         = '0;
      ram_csn_o   = 1'b1;
      ram_wen_o   = 1'b1;
      ram_be_o    = 4'h0;
      ram_addr_o  = '0;
      ram_wdata_o = 32'h0;

      // Everything is held quiet while reset is applied, even before the state register clears.
      if (!rst_i) begin
         case (state_q)
            INIT: begin
               ram_csn_o  = 1'b0;
               ram_wen_o  = 1'b0;
               ram_be_o   = 4'hF;
               ram_addr_o = fill_q;
               fill_d     = fill_q + 1'b1;
               if (fill_q == '1) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (m0_req_i && (!m1_req_i || !rr_q)) begin
                  gnt[0] = 1'b1;
               end else if (m1_req_i) begin
                  gnt[1] = 1'b1;
               end

               if (gnt[0]) begin
                  ram_csn_o   = 1'b0;
                  ram_wen_o   = m0_wen_i;
                  ram_be_o    = m0_be_i;
                  ram_addr_o  = m0_addr_i;
                  ram_wdata_o = m0_wdata_i;
               end else if (gnt[1]) begin
                  ram_csn_o   = 1'b0;
                  ram_wen_o   = m1_wen_i;
                  ram_be_o    = m1_be_i;
                  ram_addr_o  = m1_addr_i;
                  ram_wdata_o = m1_wdata_i;
               end

               // Pointer moves to the port that was not just served.
               if (|gnt) begin
                  rr_d = gnt[0];
               end
            end
            default: state_d = RESET_STATE;
         endcase
      end

      rvalid_d = gnt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= RESET_STATE;
         fill_q   <= '0;
         rr_q     <= 1'b0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         rr_q     <= rr_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign m0_gnt_o    = gnt[0];
   assign m1_gnt_o    = gnt[1];
   assign m0_rvalid_o = rvalid_q[0] && !rst_i;
   assign m1_rvalid_o = rvalid_q[1] && !rst_i;
   assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : 32'h0;
   assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : 32'h0;
   assign init_done_o = (state_q == RUN) && (!rst_i || !INIT_ZERO);

endmodule

// File: tb/tb_fpga_ram_bank_arbiter.sv
// tb/tb_fpga_ram_bank_arbiter.sv - directed vector bench for the RAM bank arbiter with a behavioural RAM
module tb_fpga_ram_bank_arbiter;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          m0_req_i, m0_gnt_o, m0_wen_i, m0_rvalid_o;
   logic [3:0]    m0_be_i;
   logic [AW-1:0] m0_addr_i;
   logic [31:0]   m0_wdata_i, m0_rdata_o;
   logic          m1_req_i, m1_gnt_o, m1_wen_i, m1_rvalid_o;
   logic [3:0]    m1_be_i;
   logic [AW-1:0] m1_addr_i;
   logic [31:0]   m1_wdata_i, m1_rdata_o;
   logic          ram_csn_o, ram_wen_o, init_done_o;
   logic [3:0]    ram_be_o;
   logic [AW-1:0] ram_addr_o;
   logic [31:0]   ram_wdata_o;
   logic [31:0]   ram_rdata_i = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpga_ram_bank_arbiter #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_wen_i(m0_wen_i), .m0_be_i(m0_be_i),
      .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_wen_i(m1_wen_i), .m1_be_i(m1_be_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .ram_csn_o(ram_csn_o), .ram_wen_o(ram_wen_o), .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .init_done_o(init_done_o)
   );

   // Behavioural RAM: byte-masked writes, one-cycle read latency, zero output on non-read cycles.
   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (!ram_csn_o && !ram_wen_o) begin
         if (ram_be_o[0]) mem[ram_addr_o][7:0]   <= ram_wdata_o[7:0];
         if (ram_be_o[1]) mem[ram_addr_o][15:8]  <= ram_wdata_o[15:8];
         if (ram_be_o[2]) mem[ram_addr_o][23:16] <= ram_wdata_o[23:16];
         if (ram_be_o[3]) mem[ram_addr_o][31:24] <= ram_wdata_o[31:24];
      end
      ram_rdata_i <= (!ram_csn_o && ram_wen_o) ? mem[ram_addr_o] : 32'h0;
   end

   typedef struct {
      logic          r0; logic w0; logic [3:0] b0; logic [AW-1:0] a0; logic [31:0] d0;
      logic          r1; logic w1; logic [3:0] b1; logic [AW-1:0] a1; logic [31:0] d1;
      logic          g0; logic g1; logic csn; logic wen; logic [3:0] be; logic [AW-1:0] addr; logic [31:0] wd;
      logic          v0; logic v1; logic [31:0] rd0; logic [31:0] rd1;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_req_i = 0; m0_wen_i = 1; m0_be_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
      m1_req_i = 0; m1_wen_i = 1; m1_be_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
   endtask

   task automatic chk_fill(input int a, input string tag);
      chk({tag, " fill csn"},   {31'b0, ram_csn_o}, 32'd0);
      chk({tag, " fill wen"},   {31'b0, ram_wen_o}, 32'd0);
      chk({tag, " fill be"},    {28'b0, ram_be_o}, 32'hF);
      chk({tag, " fill addr"},  {28'b0, ram_addr_o}, a);
      chk({tag, " fill wdata"}, ram_wdata_o, 32'h0);
      chk({tag, " fill gnt"},   {30'b0, m1_gnt_o, m0_gnt_o}, 32'd0);
      chk({tag, " fill done"},  {31'b0, init_done_o}, 32'd0);
   endtask

   initial begin
      //            m0: req wen be   addr  wdata         m1: req wen be   addr  wdata         g0 g1 csn wen be   addr  wdata          v0 v1 rd0            rd1
      vecs[0]  = '{1, 0, 4'hF, 4'd5,  32'hDEADBEEF, 0, 1, 4'h0, 4'd0,  32'h0,        1, 0, 0, 0, 4'hF, 4'd5,  32'hDEADBEEF, 0, 1, 32'h0,        32'h0};
      vecs[1]  = '{1, 1, 4'hF, 4'd5,  32'h0,        0, 1, 4'h0, 4'd0,  32'h0,        1, 0, 0, 1, 4'hF, 4'd5,  32'h0,        1, 0, 32'h0,        32'h0};
      vecs[2]  = '{0, 1, 4'h0, 4'd0,  32'h0,        0, 1, 4'h0, 4'd0,  32'h0,        0, 0, 1, 1, 4'h0, 4'd0,  32'h0,        1, 0, 32'hDEADBEEF, 32'h0};
      vecs[3]  = '{1, 0, 4'hF, 4'd2,  32'hFFFFFFFF, 1, 1, 4'hF, 4'd5,  32'h0,        0, 1, 0, 1, 4'hF, 4'd5,  32'h0,        0, 0, 32'h0,        32'h0};
      vecs[4]  = '{1, 0, 4'hF, 4'd2,  32'hFFFFFFFF, 1, 1, 4'hF, 4'd5,  32'h0,        1, 0, 0, 0, 4'hF, 4'd2,  32'hFFFFFFFF, 0, 1, 32'h0,        32'hDEADBEEF};
      vecs[5]  = '{1, 0, 4'hF, 4'd2,  32'hFFFFFFFF, 1, 1, 4'hF, 4'd5,  32'h0,        0, 1, 0, 1, 4'hF, 4'd5,  32'h0,        1, 0, 32'h0,        32'h0};
      vecs[6]  = '{1, 0, 4'h3, 4'd2,  32'h12345678, 0, 1, 4'h0, 4'd0,  32'h0,        1, 0, 0, 0, 4'h3, 4'd2,  32'h12345678, 0, 1, 32'h0,        32'hDEADBEEF};
      vecs[7]  = '{1, 1, 4'hF, 4'd2,  32'h0,        0, 1, 4'h0, 4'd0,  32'h0,        1, 0, 0, 1, 4'hF, 4'd2,  32'h0,        1, 0, 32'h0,        32'h0};
      vecs[8]  = '{0, 1, 4'h0, 4'd0,  32'h0,        0, 1, 4'h0, 4'd0,  32'h0,        0, 0, 1, 1, 4'h0, 4'd0,  32'h0,        1, 0, 32'hFFFF5678, 32'h0};
      vecs[9]  = '{0, 1, 4'h0, 4'd0,  32'h0,        1, 0, 4'hC, 4'd15, 32'hAABBCCDD, 0, 1, 0, 0, 4'hC, 4'd15, 32'hAABBCCDD, 0, 0, 32'h0,        32'h0};
      vecs[10] = '{0, 1, 4'h0, 4'd0,  32'h0,        1, 1, 4'hF, 4'd15, 32'h0,        0, 1, 0, 1, 4'hF, 4'd15, 32'h0,        0, 1, 32'h0,        32'h0};
      vecs[11] = '{0, 1, 4'h0, 4'd0,  32'h0,        0, 1, 4'h0, 4'd0,  32'h0,        0, 0, 1, 1, 4'h0, 4'd0,  32'h0,        0, 1, 32'h0,        32'hAABB0000};

      // Reset state, with a request pending that must be ignored.
      idle_inputs();
      rst_i = 1; m0_req_i = 1;
      @(negedge clk); @(negedge clk); #1;
      chk("rst gnt0",   {31'b0, m0_gnt_o}, 32'd0);
      chk("rst csn",    {31'b0, ram_csn_o}, 32'd1);
      chk("rst done",   {31'b0, init_done_o}, 32'd0);
      chk("rst rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
      chk("rst rdata",  m0_rdata_o | m1_rdata_o, 32'h0);

      // Zero-fill with m1 requesting throughout; m1 must wait for RUN.
      @(negedge clk);
      rst_i = 0; m0_req_i = 0; m1_req_i = 1; m1_wen_i = 1; m1_be_i = 4'hF; m1_addr_i = 4'd3;
      for (int i = 0; i < 16; i++) begin
         #1 chk_fill(i, "init");
         @(negedge clk);
      end
      #1;
      chk("run done",     {31'b0, init_done_o}, 32'd1);
      chk("run m1 gnt",   {31'b0, m1_gnt_o}, 32'd1);
      chk("run m1 addr",  {28'b0, ram_addr_o}, 32'd3);
      @(negedge clk);

      for (int v = 0; v < 12; v++) begin
         m0_req_i = vecs[v].r0; m0_wen_i = vecs[v].w0; m0_be_i = vecs[v].b0; m0_addr_i = vecs[v].a0; m0_wdata_i = vecs[v].d0;
         m1_req_i = vecs[v].r1; m1_wen_i = vecs[v].w1; m1_be_i = vecs[v].b1; m1_addr_i = vecs[v].a1; m1_wdata_i = vecs[v].d1;
         #1;
         chk($sformatf("v%0d gnt0", v),   {31'b0, m0_gnt_o}, {31'b0, vecs[v].g0});
         chk($sformatf("v%0d gnt1", v),   {31'b0, m1_gnt_o}, {31'b0, vecs[v].g1});
         chk($sformatf("v%0d csn", v),    {31'b0, ram_csn_o}, {31'b0, vecs[v].csn});
         chk($sformatf("v%0d wen", v),    {31'b0, ram_wen_o}, {31'b0, vecs[v].wen});
         chk($sformatf("v%0d be", v),     {28'b0, ram_be_o}, {28'b0, vecs[v].be});
         chk($sformatf("v%0d addr", v),   {28'b0, ram_addr_o}, {28'b0, vecs[v].addr});
         chk($sformatf("v%0d wdata", v),  ram_wdata_o, vecs[v].wd);
         chk($sformatf("v%0d rvalid0", v), {31'b0, m0_rvalid_o}, {31'b0, vecs[v].v0});
         chk($sformatf("v%0d rvalid1", v), {31'b0, m1_rvalid_o}, {31'b0, vecs[v].v1});
         chk($sformatf("v%0d rdata0", v), m0_rdata_o, vecs[v].rd0);
         chk($sformatf("v%0d rdata1", v), m1_rdata_o, vecs[v].rd1);
         @(negedge clk);
      end

      // Reset right after a grant drops the pending response.
      idle_inputs();
      m0_req_i = 1; m0_addr_i = 4'd5;
      #1 chk("pre-rst gnt0", {31'b0, m0_gnt_o}, 32'd1);
      @(negedge clk);
      rst_i = 1; m0_req_i = 0;
      #1 chk("rst drop rvalid", {31'b0, m0_rvalid_o}, 32'd0);
      chk("rst drop csn", {31'b0, ram_csn_o}, 32'd1);
      @(negedge clk);
      rst_i = 0; m0_req_i = 1; m1_req_i = 1;
      for (int i = 0; i < 8; i++) begin
         #1 chk_fill(i, "fill1");
         if (i == 0) chk("post-rst rvalid", {31'b0, m0_rvalid_o}, 32'd0);
         @(negedge clk);
      end

      // Reset pulse while the fill counter sits at 8 after writing 7; fill must restart at 0.
      rst_i = 1;
      #1 chk("midfill csn", {31'b0, ram_csn_o}, 32'd1);
      chk("midfill gnt", {30'b0, m1_gnt_o, m0_gnt_o}, 32'd0);
      @(negedge clk);
      rst_i = 0;
      for (int i = 0; i < 16; i++) begin
         #1 chk_fill(i, "fill2");
         @(negedge clk);
      end

      // Both masters request continuously: grants alternate starting at m0.
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin m0_req_i = 0; m1_req_i = 0; end
         #1;
         chk($sformatf("rr%0d gnt0", k), {31'b0, m0_gnt_o}, (k < 4 && k % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d gnt1", k), {31'b0, m1_gnt_o}, (k < 4 && k % 2 == 1) ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d rvalid0", k), {31'b0, m0_rvalid_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d rvalid1", k), {31'b0, m1_rvalid_o}, (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
